angle_speed_est: RTL and testbench

Downstream stage of the quadrature decoder. Takes the 16-bit scaled mechanical angle (0..65535 per mechanical revolution) and produces the electrical angle for the FOC Park/Clarke transforms and a filtered signed speed estimate for the speed loop. Speed is measured by periodic angle differencing with wrap-aware arithmetic and smoothed by a shift-based IIR. A stall detector flags a stopped rotor.

---
 rtl/foc_pkg.sv | 23 ++
 rtl/iir_shift_lpf.sv | 60 ++++++
 rtl/angle_speed_est.sv | 200 ++++++++++++++++++++
 tb/tb_angle_speed_est.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/foc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : foc_pkg                                                      |
// | Description : Shared constants and FSM state encoding for the FOC angle    |
// |               and speed estimation path.                                   |
// |               Contents: ANGLE_W (angle width), SPEED_W (speed width),      |
// |               fsm_state_t with ST_PRIME / ST_RUN / ST_STALL.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package foc_pkg;

    localparam int ANGLE_W = 16;
    localparam int SPEED_W = 16;

    // Speed-estimator FSM: PRIME captures the first reference angle, RUN
    // produces filtered deltas, STALL holds speed at zero until motion resumes.
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_PRIME = 2'd0;
    localparam fsm_state_t ST_RUN   = 2'd1;
    localparam fsm_state_t ST_STALL = 2'd2;

endpackage
`default_nettype wire

// File: rtl/iir_shift_lpf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iir_shift_lpf                                                |
// | Description : First-order shift-based IIR low-pass on a signed delta.      |
// |               acc_next = acc + delta - (acc >>> ALPHA_SHIFT)               |
// |               o_y      = (acc_next >>> ALPHA_SHIFT)[15:0]                  |
// | Ports       : clk, rst      - clock, synchronous active-high reset         |
// |               i_en          - advance the filter by one sample             |
// |               i_load        - preset acc to i_delta << ALPHA_SHIFT         |
// |               i_clear       - zero acc (highest priority)                  |
// |               i_delta [16]  - signed input sample                          |
// |               o_y     [16]  - filter output for the sample being applied   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module iir_shift_lpf #(
    parameter int ALPHA_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic signed [15:0] i_delta,
    output logic signed [15:0] o_y
);

    // One sign bit plus 16 bits of headroom above the fractional bits: the
    // steady-state value is delta * 2^ALPHA_SHIFT, which always fits.
    localparam int C_ACC_W = 17 + ALPHA_SHIFT;

    logic signed [C_ACC_W-1:0] r_acc;
    logic signed [C_ACC_W-1:0] w_acc_d;
    logic signed [C_ACC_W-1:0] w_delta_ext;
    logic signed [C_ACC_W-1:0] w_acc_next;

    always_comb begin
        w_delta_ext = {{(C_ACC_W-16){i_delta[15]}}, i_delta};
        w_acc_next  = r_acc + w_delta_ext - (r_acc >>> ALPHA_SHIFT);
        o_y         = 16'(w_acc_next >>> ALPHA_SHIFT);

        w_acc_d = r_acc;
        if (i_clear) begin
            w_acc_d = '0;
        end else if (i_load) begin
            w_acc_d = w_delta_ext <<< ALPHA_SHIFT;
        end else if (i_en) begin
            w_acc_d = w_acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/angle_speed_est.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : angle_speed_est                                              |
// | Description : Mechanical-to-electrical angle conversion with alignable     |
// |               zero, plus wrap-aware periodic speed estimate, IIR smoothing |
// |               and stall detection.                                         |
// | Ports       : clk, rst          - clock, synchronous active-high reset     |
// |               mech_angle [16]   - mechanical angle, 0..65535 per rev       |
// |               align             - capture current electrical angle as zero |
// |               elec_angle [16]   - electrical angle, 2 cycles from input    |
// |               speed      [16]   - signed filtered mech LSB per sample      |
// |               speed_valid       - one-cycle pulse on each speed update     |
// |               dir               - 1 = positive rotation                    |
// |               stalled           - rotor considered stopped                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module angle_speed_est
    import foc_pkg::*;
#(
    parameter int                POLE_PAIRS    = 4,
    parameter int                SAMPLE_DIV    = 20000,
    parameter int                ALPHA_SHIFT   = 3,
    parameter int                STALL_SAMPLES = 50,
    parameter logic [ANGLE_W-1:0] ANGLE_OFFSET = 16'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ANGLE_W-1:0]        mech_angle,
    input  logic                      align,
    output logic [ANGLE_W-1:0]        elec_angle,
    output logic signed [SPEED_W-1:0] speed,
    output logic                      speed_valid,
    output logic                      dir,
    output logic                      stalled
);

    localparam int                 C_CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_TC    = C_CNT_W'(SAMPLE_DIV - 1);
    localparam logic [ANGLE_W-1:0] C_PP    = ANGLE_W'(POLE_PAIRS);
    localparam logic [15:0]        C_STALL = 16'(STALL_SAMPLES);

    // Registered state
    logic [ANGLE_W-1:0]        r_m;
    logic [ANGLE_W-1:0]        r_offset;
    logic [ANGLE_W-1:0]        r_elec;
    logic [C_CNT_W-1:0]        r_cnt;
    fsm_state_t                r_state;
    logic [ANGLE_W-1:0]        r_prev;
    logic [15:0]               r_zcnt;
    logic signed [SPEED_W-1:0] r_speed;
    logic                      r_valid;
    logic                      r_dir;
    logic                      r_stalled;

    // Next-state values
    fsm_state_t                w_state_d;
    logic [ANGLE_W-1:0]        w_prev_d;
    logic [15:0]               w_zcnt_d;
    logic [15:0]               w_zcnt_inc;
    logic signed [SPEED_W-1:0] w_speed_d;
    logic                      w_valid_d;
    logic                      w_dir_d;
    logic                      w_stalled_d;

    // Datapath
    logic [ANGLE_W-1:0]        w_scaled;
    logic                      w_tc;
    logic signed [SPEED_W-1:0] w_delta;
    logic                      w_delta_zero;
    logic                      w_iir_en;
    logic                      w_iir_load;
    logic                      w_iir_clear;
    logic signed [SPEED_W-1:0] w_iir_y;

    iir_shift_lpf #(
        .ALPHA_SHIFT (ALPHA_SHIFT)
    ) u_lpf (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_iir_en),
        .i_load  (w_iir_load),
        .i_clear (w_iir_clear),
        .i_delta (w_delta),
        .o_y     (w_iir_y)
    );

    always_comb begin
        // Product truncated to 16 bits gives the electrical angle modulo 2^16.
        w_scaled     = r_m * C_PP;
        w_tc         = (r_cnt == C_TC);
        // Modular subtraction reinterpreted as signed handles the 0xFFFF->0x0000 wrap.
        w_delta      = $signed(r_m - r_prev);
        w_delta_zero = (w_delta == 16'sd0);
        w_zcnt_inc   = r_zcnt + 16'd1;

        w_state_d   = r_state;
        w_prev_d    = r_prev;
        w_zcnt_d    = r_zcnt;
        w_speed_d   = r_speed;
        w_valid_d   = 1'b0;
        w_dir_d     = r_dir;
        w_stalled_d = r_stalled;
        w_iir_en    = 1'b0;
        w_iir_load  = 1'b0;
        w_iir_clear = 1'b0;

        case (r_state)
            ST_PRIME: begin
                if (w_tc) begin
                    w_prev_d  = r_m;
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tc) begin
                    w_prev_d  = r_m;
                    w_valid_d = 1'b1;
                    w_iir_en  = 1'b1;
                    w_speed_d = w_iir_y;
                    w_zcnt_d  = w_delta_zero ? w_zcnt_inc : 16'd0;
                    if (w_delta_zero && (w_zcnt_inc == C_STALL)) begin
                        w_state_d   = ST_STALL;
                        w_stalled_d = 1'b1;
                        w_speed_d   = '0;
                        w_iir_clear = 1'b1;
                    end
                end
            end
            ST_STALL: begin
                if (w_tc) begin
                    w_prev_d  = r_m;
                    w_valid_d = 1'b1;
                    if (!w_delta_zero) begin
                        // Restart the filter at the observed delta so speed
                        // reflects motion immediately rather than ramping up.
                        w_iir_load  = 1'b1;
                        w_speed_d   = w_delta;
                        w_zcnt_d    = 16'd0;
                        w_stalled_d = 1'b0;
                        w_state_d   = ST_RUN;
                    end else begin
                        w_iir_clear = 1'b1;
                        w_speed_d   = '0;
                    end
                end
            end
            default: begin
                w_state_d = ST_PRIME;
            end
        endcase

        // Direction follows the sign of each new speed; zero keeps the last one.
        if (w_valid_d) begin
            if (w_speed_d[SPEED_W-1]) begin
                w_dir_d = 1'b0;
            end else if (w_speed_d != '0) begin
                w_dir_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= '0;
            r_offset  <= ANGLE_OFFSET;
            r_elec    <= '0;
            r_cnt     <= '0;
            r_state   <= ST_PRIME;
            r_prev    <= '0;
            r_zcnt    <= '0;
            r_speed   <= '0;
            r_valid   <= 1'b0;
            r_dir     <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_m  <= mech_angle;
            // The edge that captures a new offset still reports against the old one.
            r_elec <= w_scaled - r_offset;
            if (align) begin
                r_offset <= w_scaled;
            end
            r_cnt     <= w_tc ? '0 : r_cnt + 1'b1;
            r_state   <= w_state_d;
            r_prev    <= w_prev_d;
            r_zcnt    <= w_zcnt_d;
            r_speed   <= w_speed_d;
            r_valid   <= w_valid_d;
            r_dir     <= w_dir_d;
            r_stalled <= w_stalled_d;
        end
    end

    assign elec_angle  = r_elec;
    assign speed       = r_speed;
    assign speed_valid = r_valid;
    assign dir         = r_dir;
    assign stalled     = r_stalled;

endmodule
`default_nettype wire

// File: tb/tb_angle_speed_est.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_angle_speed_est                                           |
// | Description : Self-checking bench for angle_speed_est. Two instances share |
// |               stimulus: ALPHA_SHIFT=0 (raw deltas) and ALPHA_SHIFT=2       |
// |               (filtered), both with SAMPLE_DIV=10 and STALL_SAMPLES=3.     |
// |               Expected values come from a per-sample-period model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_angle_speed_est;

    localparam int SD = 10;
    localparam int SS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        align = 1'b0;
    logic [15:0] mech_angle = 16'h0000;

    logic [15:0]        elec_angle, elec_angle_f;
    logic signed [15:0] speed, speed_f;
    logic               speed_valid, speed_valid_f;
    logic               dir, dir_f;
    logic               stalled, stalled_f;

    int n_cmp = 0;
    int n_err = 0;

    // Period-level model state
    logic [15:0] m_off;
    logic [15:0] m_prev;
    logic [15:0] cur;
    bit          m_primed;
    bit          m_stalled;
    bit          m_dir;
    bit          m_dir_f;
    int          m_zc;
    int          m_spd;
    int          m_acc_f;
    int          m_spd_f;

    angle_speed_est #(
        .POLE_PAIRS(4), .SAMPLE_DIV(SD), .ALPHA_SHIFT(0), .STALL_SAMPLES(SS), .ANGLE_OFFSET(16'd0)
    ) u_dut (
        .clk(clk), .rst(rst), .mech_angle(mech_angle), .align(align),
        .elec_angle(elec_angle), .speed(speed), .speed_valid(speed_valid),
        .dir(dir), .stalled(stalled)
    );

    angle_speed_est #(
        .POLE_PAIRS(4), .SAMPLE_DIV(SD), .ALPHA_SHIFT(2), .STALL_SAMPLES(SS), .ANGLE_OFFSET(16'd0)
    ) u_dut_f (
        .clk(clk), .rst(rst), .mech_angle(mech_angle), .align(align),
        .elec_angle(elec_angle_f), .speed(speed_f), .speed_valid(speed_valid_f),
        .dir(dir_f), .stalled(stalled_f)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_off     = 16'h0000;
        m_prev    = 16'h0000;
        m_primed  = 1'b0;
        m_stalled = 1'b0;
        m_dir     = 1'b0;
        m_dir_f   = 1'b0;
        m_zc      = 0;
        m_spd     = 0;
        m_acc_f   = 0;
        m_spd_f   = 0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_elec",    elec_angle, 16'h0000);
        chk("rst_speed",   speed, 16'h0000);
        chk("rst_valid",   {15'd0, speed_valid}, 16'h0000);
        chk("rst_dir",     {15'd0, dir}, 16'h0000);
        chk("rst_stalled", {15'd0, stalled}, 16'h0000);
        chk("rst_speed_f", speed_f, 16'h0000);
        chk("rst_valid_f", {15'd0, speed_valid_f}, 16'h0000);
    endtask

    // One full sample period starting with the sample counter at zero:
    // hold angle a for SD cycles, optionally pulsing align mid-period.
    task automatic period(input logic [15:0] a, input bit do_align);
        int t;
        logic signed [15:0] ds;
        int d;
        bit exp_valid;
        mech_angle = a;
        tick(); tick();
        t = 2;
        chk("elec", elec_angle, 16'(a * 4 - m_off));
        chk("valid_idle", {15'd0, speed_valid}, 16'h0000);
        if (do_align) begin
            align = 1'b1;
            tick();
            align = 1'b0;
            chk("elec_align_old", elec_angle, 16'(a * 4 - m_off));
            m_off = 16'(a * 4);
            tick();
            t = 4;
            chk("elec_align_new", elec_angle, 16'(a * 4 - m_off));
        end
        while (t < SD - 1) begin
            tick();
            t++;
            chk("valid_idle", {15'd0, speed_valid}, 16'h0000);
        end
        tick();

        exp_valid = 1'b0;
        if (!m_primed) begin
            m_primed = 1'b1;
        end else begin
            exp_valid = 1'b1;
            ds = a - m_prev;
            d  = int'(ds);
            if (!m_stalled) begin
                if (d == 0) m_zc++; else m_zc = 0;
                if (m_zc == SS) begin
                    m_stalled = 1'b1;
                    m_spd     = 0;
                    m_acc_f   = 0;
                    m_spd_f   = 0;
                end else begin
                    m_spd   = d;
                    m_acc_f = m_acc_f + d - (m_acc_f >>> 2);
                    m_spd_f = m_acc_f >>> 2;
                end
            end else if (d != 0) begin
                m_stalled = 1'b0;
                m_zc      = 0;
                m_spd     = d;
                m_acc_f   = d * 4;
                m_spd_f   = d;
            end else begin
                m_spd   = 0;
                m_spd_f = 0;
            end
            if (m_spd > 0) m_dir = 1'b1; else if (m_spd < 0) m_dir = 1'b0;
            if (m_spd_f > 0) m_dir_f = 1'b1; else if (m_spd_f < 0) m_dir_f = 1'b0;
        end
        m_prev = a;

        chk("valid",   {15'd0, speed_valid}, {15'd0, exp_valid});
        chk("valid_f", {15'd0, speed_valid_f}, {15'd0, exp_valid});
        chk("stalled", {15'd0, stalled}, {15'd0, m_stalled});
        chk("dir",     {15'd0, dir}, {15'd0, m_dir});
        chk("dir_f",   {15'd0, dir_f}, {15'd0, m_dir_f});
        if (exp_valid) begin
            chk("speed",   speed, 16'(m_spd));
            chk("speed_f", speed_f, 16'(m_spd_f));
        end
    endtask

    initial begin
        int d;
        model_reset();

        // Reset state
        rst = 1'b1;
        mech_angle = 16'h1000;
        tick(); tick(); tick();
        chk_reset_outputs();
        rst = 1'b0;

        // Latency (prime period), then align and post-align offset
        period(16'h1000, 1'b0);
        period(16'h1234, 1'b1);
        period(16'h1235, 1'b0);
        chk("elec_after_align", elec_angle, 16'h0004);

        // Forward through the wrap, then reverse
        period(16'hFF5C, 1'b0);
        period(16'hFFC0, 1'b0);
        period(16'h0024, 1'b0);
        chk("wrap_fwd_speed", speed, 16'd100);
        chk("wrap_fwd_dir", {15'd0, dir}, 16'h0001);
        period(16'h0088, 1'b0);
        period(16'h0024, 1'b0);
        period(16'hFFC0, 1'b0);
        chk("rev_speed", speed, 16'hFF9C);
        chk("rev_dir", {15'd0, dir}, 16'h0000);
        period(16'hFF5C, 1'b0);

        // Stall: three frozen samples, one more while stalled, then resume
        period(16'hFF5C, 1'b0);
        period(16'hFF5C, 1'b0);
        period(16'hFF5C, 1'b0);
        chk("stall_set", {15'd0, stalled}, 16'h0001);
        chk("stall_speed", speed, 16'h0000);
        period(16'hFF5C, 1'b0);
        period(16'hFF61, 1'b0);
        chk("stall_exit", {15'd0, stalled}, 16'h0000);
        chk("stall_exit_speed", speed, 16'd5);
        chk("stall_exit_speed_f", speed_f, 16'd5);

        // Randomised motion with occasional freezes and alignments
        cur = 16'hFF61;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) d = 0;
            else d = int'($urandom_range(0, 40000)) - 20000;
            cur = 16'(int'(cur) + d);
            period(cur, ($urandom_range(0, 4) == 0));
        end

        // Mid-run reset
        mech_angle = cur;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick(); tick();
        chk_reset_outputs();
        rst = 1'b0;
        model_reset();

        // Filter step response (ALPHA_SHIFT=2): 16, 28, 37, 43, ... toward 64
        cur = 16'h2000;
        period(cur, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cur = cur + 16'd64;
            period(cur, 1'b0);
            if (k == 0) chk("filt_first", speed_f, 16'd16);
            if (k == 3) chk("filt_fourth", speed_f, 16'd43);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard ceiling so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
